// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: add/subtract unit that resolves one WIDTH/STAGES-bit slice per stage, with carry, overflow and zero flags
module pipelined_add_sub #(
  parameter int WIDTH = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int SLICE = WIDTH / STAGES;
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic [WIDTH-1:0] ia [STAGES];
  logic [WIDTH-1:0] ib [STAGES];
  logic [WIDTH-1:0] nr [STAGES];
  logic [SLICE:0] s [STAGES];
  logic c_q [STAGES];
  logic v_q [STAGES];
  logic ic [STAGES];
  logic iv [STAGES];
  logic en [STAGES];
  logic ov_q, z_q;
  always_comb begin
    en[STAGES-1] = !v_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) en[k] = !v_q[k] || en[k+1];
    in_ready = !flush && en[0];
    ia[0] = operand_a;
    ib[0] = sub ? ~operand_b : operand_b;
    nr[0] = '0;
    ic[0] = sub | carry_in;
    iv[0] = in_valid && in_ready;
    for (int k = 1; k < STAGES; k++) begin
      ia[k] = a_q[k-1];
      ib[k] = b_q[k-1];
      nr[k] = r_q[k-1];
      ic[k] = c_q[k-1];
      iv[k] = v_q[k-1];
    end
    // each stage overwrites only its own slice; lower slices ride along unchanged
    for (int k = 0; k < STAGES; k++) begin
      s[k] = {1'b0, ia[k][k*SLICE +: SLICE]} + {1'b0, ib[k][k*SLICE +: SLICE]} + {{SLICE{1'b0}}, ic[k]};
      nr[k][k*SLICE +: SLICE] = s[k][SLICE-1:0];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ov_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= flush ? 1'b0 : en[k] ? iv[k] : v_q[k];
        if (en[k] && iv[k]) begin
          a_q[k] <= ia[k];
          b_q[k] <= ib[k];
          r_q[k] <= nr[k];
          c_q[k] <= s[k][SLICE];
        end
      end
      if (en[STAGES-1] && iv[STAGES-1]) begin
        ov_q <= (ia[STAGES-1][WIDTH-1] == ib[STAGES-1][WIDTH-1]) && (nr[STAGES-1][WIDTH-1] != ia[STAGES-1][WIDTH-1]);
        z_q <= nr[STAGES-1] == '0;
      end
    end
  end
  assign out_valid = v_q[STAGES-1];
  assign result = r_q[STAGES-1];
  assign carry_out = c_q[STAGES-1];
  assign overflow = ov_q;
  assign zero = z_q;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed vectors, streaming/stall, flush and async reset checks for pipelined_add_sub
module tb_pipelined_add_sub;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic in_valid = 1'b0, in_ready, sub = 1'b0, cin = 1'b0;
  logic [31:0] a = '0, b = '0, result;
  logic out_valid, out_ready = 1'b1, co, ov, zr;
  logic x_valid = 1'b0, x_sub = 1'b0, x_cin = 1'b0;
  logic [63:0] x_a = '0, x_b = '0, xr8;
  logic [15:0] xr1;
  logic xv8, xc8, xo8, xz8, xir8, xv1, xc1, xo1, xz1, xir1;
  int n_tests = 0, n_fail = 0;
  logic mon = 1'b0, hold_v = 1'b0;
  logic [31:0] hold_r;
  logic [31:0] q [$];
  int n_rx = 0;
  always #5 clk = ~clk;
  pipelined_add_sub #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(a), .operand_b(b), .sub(sub), .carry_in(cin), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry_out(co), .overflow(ov), .zero(zr));
  pipelined_add_sub #(.WIDTH(64), .STAGES(8)) u8 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(x_valid), .in_ready(xir8),
    .operand_a(x_a), .operand_b(x_b), .sub(x_sub), .carry_in(x_cin), .out_valid(xv8),
    .out_ready(1'b1), .result(xr8), .carry_out(xc8), .overflow(xo8), .zero(xz8));
  pipelined_add_sub #(.WIDTH(16), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(x_valid), .in_ready(xir1),
    .operand_a(x_a[15:0]), .operand_b(x_b[15:0]), .sub(x_sub), .carry_in(x_cin), .out_valid(xv1),
    .out_ready(1'b1), .result(xr1), .carry_out(xc1), .overflow(xo1), .zero(xz1));
  typedef struct {
    logic [31:0] a, b;
    logic s, ci;
    logic [31:0] r;
    logic c, o, z;
  } vec_t;
  vec_t vt [11];
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction
  // scoreboard: results consumed in order, and held stable while stalled
  always @(negedge clk) if (mon) begin
    #3;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got result %h with nothing pending", result);
      end else begin
        chk("stream_result", result, q.pop_front());
        n_rx++;
      end
    end
    if (out_valid && !out_ready) begin
      if (hold_v) chk("hold_result", result, hold_r);
      hold_v = 1'b1;
      hold_r = result;
    end else hold_v = 1'b0;
  end
  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; a = v.a; b = v.b; sub = v.s; cin = v.ci; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 2);
    chk("result", result, v.r);
    chk("carry_out", co, v.c);
    chk("overflow", ov, v.o);
    chk("zero", zr, v.z);
  endtask
  task automatic run_x(input logic [63:0] xa, xb, input logic s, ci,
                       input logic [63:0] e8, input logic c8, o8, z8,
                       input logic [15:0] e1, input logic c1, o1, z1);
    logic seen1, done8;
    seen1 = 1'b0;
    done8 = 1'b0;
    @(negedge clk);
    x_valid = 1'b1; x_a = xa; x_b = xb; x_sub = s; x_cin = ci;
    @(negedge clk);
    x_valid = 1'b0;
    for (int lat = 1; lat <= 20 && !done8; lat++) begin
      if (xv1) begin
        seen1 = 1'b1;
        chk("w16_latency", lat, 1);
        chk("w16_result", xr1, e1);
        chk("w16_flags", {xc1, xo1, xz1}, {c1, o1, z1});
      end
      if (xv8) begin
        done8 = 1'b1;
        chk("w64_latency", lat, 8);
        chk("w64_result", xr8, e8);
        chk("w64_flags", {xc8, xo8, xz8}, {c8, o8, z8});
      end
      if (!done8) @(negedge clk);
    end
    chk("w16_seen", seen1, 1);
    chk("w64_seen", done8, 1);
  endtask
  initial begin
    int sent;
    logic saw_block;
    logic [31:0] sa, sb, ss;
    vt[0]  = '{32'h0000_FFFF, 32'h1, 0, 0, 32'h0001_0000, 0, 0, 0};
    vt[1]  = '{32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1, 0};
    vt[2]  = '{32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0,         1, 0, 1};
    vt[3]  = '{32'h5,         32'h7, 1, 0, 32'hFFFF_FFFE, 0, 0, 0};
    vt[4]  = '{32'h8000_0000, 32'h1, 1, 0, 32'h7FFF_FFFF, 1, 1, 0};
    vt[5]  = '{32'h5,         32'h5, 1, 0, 32'h0,         1, 0, 1};
    vt[6]  = '{32'h1,         32'h1, 0, 1, 32'h3,         0, 0, 0};
    vt[7]  = '{32'hA,         32'h3, 1, 1, 32'h7,         1, 0, 0};
    vt[8]  = '{32'h0000_FFFF, 32'h0, 0, 1, 32'h0001_0000, 0, 0, 0};
    vt[9]  = '{32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0, 1, 1, 1};
    vt[10] = '{32'h0,         32'h0, 1, 0, 32'h0,         1, 0, 1};
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_outputs", {result, co, ov, zr}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    for (int i = 0; i < 11; i++) run_vec(vt[i]);
    run_x(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 64'h0, 1, 0, 1, 16'h0, 1, 0, 1);
    run_x(64'h7FFF_FFFF_FFFF_7FFF, 64'h1, 0, 0, 64'h7FFF_FFFF_FFFF_8000, 0, 0, 0, 16'h8000, 0, 1, 0);
    run_x(64'h8000_0000_0000_8000, 64'h1, 1, 0, 64'h8000_0000_0000_7FFF, 1, 0, 0, 16'h7FFF, 1, 1, 0);
    run_x(64'h3, 64'h5, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 16'hFFFE, 0, 0, 0);
    @(negedge clk);
    mon = 1'b1;
    sent = 0;
    saw_block = 1'b0;
    sub = 1'b0;
    cin = 1'b0;
    for (int cyc = 0; cyc < 60 && (sent < 12 || q.size() > 0); cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 8);
      in_valid = sent < 12;
      sa = 32'h1000_0001 * sent + 32'hFFFF;
      sb = 32'd7 * sent;
      a = sa;
      b = sb;
      #1;
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) begin
        ss = sa + sb;
        q.push_back(ss);
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_sent", sent, 12);
    chk("stream_drained", q.size(), 0);
    chk("stream_received", n_rx, 12);
    chk("stall_blocks_input", saw_block, 1);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h11; b = 32'h22;
    @(negedge clk);
    a = 32'h33; b = 32'h44;
    @(negedge clk);
    chk("flush_pre_valid", out_valid, 1);
    flush = 1'b1;
    a = 32'h55; b = 32'h66;
    #1;
    chk("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("flush_no_output", out_valid, 0);
    end
    mon = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h8000_0000; b = 32'h8000_0000; sub = 1'b0;
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_reset_flags", {out_valid, co, ov, zr}, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", out_valid, 0);
    chk("async_reset_outputs", {result, co, ov, zr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_discards", out_valid, 0);
    end
    run_vec(vt[4]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
